// File: rtl/aer_pkg.sv
// Shared types and helpers for the address-event transmitter.
package aer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Widest spike vector the one-hot helper accepts; narrower vectors are zero-extended.
    localparam int ONEHOT_MAX_W = 256;

    // True when exactly one bit of v is set.
    function automatic logic is_one_hot(input logic [ONEHOT_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/aer_arbiter.sv
// Combinational address arbiter: lowest-index-first or round-robin after rr_ptr.
module aer_arbiter
    import aer_pkg::*;
#(
    parameter int NO_OF_NEURONS = 5,
    localparam int ADDR_W = $clog2(NO_OF_NEURONS)
) (
    input  logic [NO_OF_NEURONS-1:0] req,
    input  logic [ADDR_W-1:0]        rr_ptr,
    input  logic                     mode,
    output logic [ADDR_W-1:0]        grant,
    output logic                     grant_valid
);

    logic              lo_found;
    logic [ADDR_W-1:0] lo_idx;
    logic              hi_found;
    logic [ADDR_W-1:0] hi_idx;

    // Find the lowest set index overall and the lowest set index above rr_ptr.
    always_comb begin
        lo_found = 1'b0;
        lo_idx   = '0;
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int unsigned i = 0; i < NO_OF_NEURONS; i++) begin
            if (req[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = ADDR_W'(i);
            end
            if (req[i] && !hi_found && (ADDR_W'(i) > rr_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = ADDR_W'(i);
            end
        end
        grant_valid = lo_found;
        grant       = (mode && hi_found) ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/aer_transmitter.sv
// Address-event transmitter: buffers nonzero spike frames in a circular FIFO and
// serialises each frame into one neuron address per valid/ready beat.
module aer_transmitter
    import aer_pkg::*;
#(
    parameter int NO_OF_NEURONS = 5,
    parameter int FIFO_DEPTH    = 4,
    parameter int ARB_MODE      = 0,
    parameter int CNT_W         = 16,
    localparam int ADDR_W = $clog2(NO_OF_NEURONS),
    localparam int CW     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NO_OF_NEURONS-1:0] spikes,
    output logic                     spikes_ready,
    output logic [ADDR_W-1:0]        aer_addr,
    output logic                     aer_valid,
    output logic                     aer_last,
    input  logic                     aer_ready,
    output logic [CW-1:0]            fifo_count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    input  logic                     clr_overflow
);

    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [NO_OF_NEURONS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;

    state_e                   state_q, state_d;
    logic [NO_OF_NEURONS-1:0] frame_q, frame_d;
    logic [ADDR_W-1:0]        rr_q, rr_d;
    logic                     valid_q, valid_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     last_q, last_d;
    logic                     ovf_q, ovf_d;
    logic [CNT_W-1:0]         drop_q, drop_d;

    logic                     push, pop, drop, load_out;
    logic [ADDR_W-1:0]        grant;
    logic                     grant_valid;

    assign spikes_ready = (count_q < DEPTH_C);
    assign fifo_count   = count_q;
    assign aer_valid    = valid_q;
    assign aer_addr     = addr_q;
    assign aer_last     = last_q;
    assign overflow     = ovf_q;
    assign drop_count   = drop_q;

    // Grant is taken over the frame as it will stand after this edge so outputs can be registered.
    aer_arbiter #(
        .NO_OF_NEURONS(NO_OF_NEURONS)
    ) u_arbiter (
        .req        (frame_d),
        .rr_ptr     (rr_d),
        .mode       (ARB_MODE == ARB_RR),
        .grant      (grant),
        .grant_valid(grant_valid)
    );

    // Sequencer: load a frame, present it one beat later, retire bits on each handshake.
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        rr_d     = rr_q;
        valid_d  = valid_q;
        pop      = 1'b0;
        load_out = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    frame_d = mem_q[rd_ptr_q];
                    state_d = SEND;
                end
            end
            SEND: begin
                // First cycle in SEND only publishes the freshly loaded frame.
                if (!valid_q) begin
                    valid_d  = 1'b1;
                    load_out = 1'b1;
                end else if (aer_ready) begin
                    frame_d  = frame_q & ~(NO_OF_NEURONS'(1) << addr_q);
                    rr_d     = addr_q;
                    load_out = 1'b1;
                    if (last_q) begin
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            frame_d = mem_q[rd_ptr_q];
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Next beat's address and last flag; held while the current beat is stalled.
    always_comb begin
        addr_d = addr_q;
        last_d = last_q;
        if (!valid_d) begin
            addr_d = '0;
            last_d = 1'b0;
        end else if (load_out && grant_valid) begin
            addr_d = grant;
            last_d = is_one_hot(ONEHOT_MAX_W'(frame_d));
        end
    end

    // FIFO pointer/count bookkeeping and drop accounting.
    always_comb begin
        push     = (|spikes) && spikes_ready;
        drop     = (|spikes) && !spikes_ready;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clr_overflow) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    // Frame storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= spikes;
        end
    end

    // State, pointer and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            frame_q  <= '0;
            rr_q     <= ADDR_W'(NO_OF_NEURONS - 1);
            valid_q  <= 1'b0;
            addr_q   <= '0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            frame_q  <= frame_d;
            rr_q     <= rr_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_aer_transmitter.sv
// Self-checking bench for aer_transmitter: fixed-priority and round-robin instances
// share one stimulus; a queue-level model predicts every output each cycle.
module tb_aer_transmitter;

    localparam int N   = 5;
    localparam int D   = 4;
    localparam int AW  = 3;
    localparam int CW  = 3;
    localparam int CNT = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   spikes = '0;
    logic           aer_ready = 1'b1;
    logic           clr = 1'b0;

    logic           rdy0, rdy1, v0, v1, l0, l1, ov0, ov1;
    logic [AW-1:0]  addr0, addr1;
    logic [CW-1:0]  cnt0, cnt1;
    logic [CNT-1:0] dc0, dc1;

    int checks = 0;
    int errors = 0;

    int log0[$];
    int last0[$];
    int log1[$];
    int e[$];

    // Model state
    int  mq[$];
    bit  m_busy = 0;
    bit  m_valid = 0;
    int  m_frame[2] = '{0, 0};
    int  m_rr[2] = '{N - 1, N - 1};
    bit  m_ov = 0;
    int  m_dc = 0;

    always #5 clk = ~clk;

    aer_transmitter #(.NO_OF_NEURONS(N), .FIFO_DEPTH(D), .ARB_MODE(0), .CNT_W(CNT)) dut0 (
        .clk(clk), .reset(reset), .spikes(spikes), .spikes_ready(rdy0),
        .aer_addr(addr0), .aer_valid(v0), .aer_last(l0), .aer_ready(aer_ready),
        .fifo_count(cnt0), .overflow(ov0), .drop_count(dc0), .clr_overflow(clr)
    );

    aer_transmitter #(.NO_OF_NEURONS(N), .FIFO_DEPTH(D), .ARB_MODE(1), .CNT_W(CNT)) dut1 (
        .clk(clk), .reset(reset), .spikes(spikes), .spikes_ready(rdy1),
        .aer_addr(addr1), .aer_valid(v1), .aer_last(l1), .aer_ready(aer_ready),
        .fifo_count(cnt1), .overflow(ov1), .drop_count(dc1), .clr_overflow(clr)
    );

    // Mode 0: scan from index 0. Mode 1: scan circularly starting just after rr.
    function automatic int m_arb(int f, int mode, int rr);
        int start;
        start = (mode == 1) ? (rr + 1) % N : 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (f[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic int m_bits(int f);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(f[i]);
        return c;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_seq(string nm, int act[$], int exp[$]);
        bit    ok;
        string sa, se;
        ok = (act.size() == exp.size());
        if (ok) foreach (exp[i]) if (act[i] != exp[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            sa = "";
            se = "";
            foreach (act[i]) sa = {sa, $sformatf("%0d ", act[i])};
            foreach (exp[i]) se = {se, $sformatf("%0d ", exp[i])};
            $display("FAIL %s actual={ %s} required={ %s}", nm, sa, se);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log0.delete();
        last0.delete();
        log1.delete();
    endtask

    // Behavioural model: frame queue, one frame in service, a one-cycle publish step,
    // one bit retired per accepted beat, next frame taken at once after the last beat.
    always @(posedge clk) begin
        int  sp, head, g;
        bit  push, drop, pop_ok;
        sp = int'(spikes);
        if (reset) begin
            mq.delete();
            m_busy = 0;
            m_valid = 0;
            m_frame = '{0, 0};
            m_rr = '{N - 1, N - 1};
            m_ov = 0;
            m_dc = 0;
        end else begin
            push = (sp != 0) && (mq.size() < D);
            drop = (sp != 0) && (mq.size() >= D);
            head = (mq.size() > 0) ? mq[0] : 0;
            pop_ok = 0;
            if (!m_busy) begin
                if (mq.size() > 0) begin
                    pop_ok = 1;
                    m_busy = 1;
                    m_valid = 0;
                    m_frame = '{head, head};
                end
            end else if (!m_valid) begin
                m_valid = 1;
            end else if (aer_ready) begin
                for (int m = 0; m < 2; m++) begin
                    g = m_arb(m_frame[m], m, m_rr[m]);
                    m_frame[m] = m_frame[m] & ~(1 << g);
                    m_rr[m] = g;
                end
                if (m_frame[0] == 0) begin
                    if (mq.size() > 0) begin
                        pop_ok = 1;
                        m_frame = '{head, head};
                    end else begin
                        m_busy = 0;
                        m_valid = 0;
                    end
                end
            end
            if (pop_ok) void'(mq.pop_front());
            if (push) mq.push_back(sp);
            if (clr) begin
                m_ov = 0;
                m_dc = 0;
            end else if (drop) begin
                m_ov = 1;
                if (m_dc < (1 << CNT) - 1) m_dc++;
            end
        end
    end

    task automatic cmp_dut(int m, logic v, logic [AW-1:0] a, logic l, logic [CW-1:0] c,
                           logic r, logic o, logic [CNT-1:0] d);
        chk($sformatf("m%0d_valid", m), v, m_valid);
        chk($sformatf("m%0d_fifo_count", m), c, mq.size());
        chk($sformatf("m%0d_spikes_ready", m), r, mq.size() < D);
        chk($sformatf("m%0d_overflow", m), o, m_ov);
        chk($sformatf("m%0d_drop_count", m), d, m_dc);
        if (m_valid) begin
            chk($sformatf("m%0d_addr", m), a, m_arb(m_frame[m], m, m_rr[m]));
            chk($sformatf("m%0d_last", m), l, m_bits(m_frame[m]) == 1);
        end
    endtask

    // Per-cycle comparison against the model, plus a log of accepted beats.
    always @(negedge clk) begin
        cmp_dut(0, v0, addr0, l0, cnt0, rdy0, ov0, dc0);
        cmp_dut(1, v1, addr1, l1, cnt1, rdy1, ov1, dc1);
        if (v0 && aer_ready) begin
            log0.push_back(int'(addr0));
            last0.push_back(int'(l0));
        end
        if (v1 && aer_ready) log1.push_back(int'(addr1));
    end

    initial begin
        int fr[6];
        cyc(2);
        chk("reset_valid", v0, 0);
        chk("reset_last", l0, 0);
        chk("reset_addr", addr0, 0);
        chk("reset_count", cnt0, 0);
        chk("reset_ready", rdy0, 1);
        chk("reset_ovf", ov0, 0);
        chk("reset_drops", dc0, 0);
        reset = 1'b0;

        // Fixed order, latency and one-beat-per-cycle throughput
        cyc(1);
        clear_logs();
        spikes = 5'b10110;
        cyc(1);
        spikes = '0;
        chk("lat_t0_valid", v0, 0);
        cyc(1);
        chk("lat_t1_valid", v0, 0);
        cyc(1);
        chk("lat_t2_valid", v0, 1);
        chk("beat1_addr", addr0, 1);
        chk("beat1_last", l0, 0);
        cyc(1);
        chk("beat2_addr", addr0, 2);
        chk("beat2_last", l0, 0);
        cyc(1);
        chk("beat3_addr", addr0, 4);
        chk("beat3_last", l0, 1);
        cyc(1);
        chk("after_frame_valid", v0, 0);
        e = {1, 2, 4};
        chk_seq("fixed_order", log0, e);
        chk_seq("rr_single_frame", log1, e);
        e = {0, 0, 1};
        chk_seq("fixed_last_flags", last0, e);

        // Backpressure on the first beat
        cyc(2);
        clear_logs();
        spikes = 5'b10110;
        cyc(1);
        spikes = '0;
        cyc(2);
        chk("bp_first_valid", v0, 1);
        chk("bp_first_addr", addr0, 1);
        aer_ready = 1'b0;
        repeat (3) begin
            cyc(1);
            chk("bp_hold_valid", v0, 1);
            chk("bp_hold_addr", addr0, 1);
            chk("bp_hold_last", l0, 0);
        end
        aer_ready = 1'b1;
        cyc(6);
        e = {1, 2, 4};
        chk_seq("bp_sequence", log0, e);
        chk_seq("bp_sequence_rr", log1, e);

        // Round-robin versus fixed priority across two frames
        clear_logs();
        spikes = 5'b00010;
        cyc(1);
        spikes = 5'b00101;
        cyc(1);
        spikes = '0;
        cyc(8);
        e = {1, 0, 2};
        chk_seq("fixed_two_frames", log0, e);
        e = {1, 2, 0};
        chk_seq("rr_two_frames", log1, e);

        // Overflow with a stalled sink
        clear_logs();
        aer_ready = 1'b0;
        fr = '{1, 2, 4, 8, 16, 3};
        foreach (fr[i]) begin
            spikes = N'(fr[i]);
            cyc(1);
        end
        spikes = '0;
        chk("ovf_count_full", cnt0, 4);
        chk("ovf_ready_low", rdy0, 0);
        chk("ovf_flag", ov0, 1);
        chk("ovf_drops", dc0, 1);
        chk("ovf_head_addr", addr0, 0);
        chk("ovf_rr_count_full", cnt1, 4);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("clr_flag", ov0, 0);
        chk("clr_drops", dc0, 0);
        spikes = 5'b00001;
        clr = 1'b1;
        cyc(1);
        spikes = '0;
        clr = 1'b0;
        chk("clr_priority_flag", ov0, 0);
        chk("clr_priority_drops", dc0, 0);
        aer_ready = 1'b1;
        cyc(12);
        e = {0, 1, 2, 3, 4};
        chk_seq("ovf_drain", log0, e);
        chk_seq("ovf_drain_rr", log1, e);
        chk("ovf_drain_count", cnt0, 0);

        // Back-to-back frames separated by an all-zero vector
        clear_logs();
        spikes = 5'b00001;
        cyc(1);
        spikes = 5'b00000;
        cyc(1);
        chk("zero_not_counted", cnt0, 0);
        spikes = 5'b01000;
        cyc(1);
        spikes = '0;
        chk("b2b_count", cnt0, 1);
        cyc(6);
        e = {0, 3};
        chk_seq("b2b_addrs", log0, e);
        e = {1, 1};
        chk_seq("b2b_last_flags", last0, e);

        // Reset in the middle of a frame with another frame queued
        clear_logs();
        spikes = 5'b11111;
        cyc(1);
        spikes = 5'b00100;
        cyc(1);
        spikes = '0;
        cyc(2);
        chk("mid_second_beat", addr0, 1);
        chk("mid_queued", cnt0, 1);
        reset = 1'b1;
        cyc(1);
        chk("rst_mid_valid", v0, 0);
        chk("rst_mid_count", cnt0, 0);
        chk("rst_mid_valid_rr", v1, 0);
        reset = 1'b0;
        clear_logs();
        spikes = 5'b11111;
        cyc(1);
        spikes = '0;
        cyc(8);
        e = {0, 1, 2, 3, 4};
        chk_seq("post_reset_frame", log0, e);
        chk_seq("post_reset_frame_rr", log1, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
